fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencing controller sitting directly in front of the instruction fetch unit. It arbitrates every PC-redirect source, drives the fetch unit's PC-control inputs, and decides which source wins each cycle. The sources are exception entry, ERET return, branch/jump resolution and hazard stalls. It buffers a branch target that resolves while the front end is stalled, and freezes fetch after an instruction-address fault until the exception is taken.

## Interface
Parameters:
- HANDLER_PC, 32'h0000_4180, exception vector.
- IM_INIT, 32'h0000_3000, first valid instruction address.
- IM_END, 32'h0000_4FFC, last valid instruction address.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- stall_req  in  1  decode hazard stall request.
- br_valid  in  1  branch/jump taken, resolved in decode this cycle.
- br_target  in  32  taken target.
- exc_req  in  1  exception/interrupt committed by CP0 this cycle.
- eret_req  in  1  ERET committed this cycle.
- epc  in  32  return address for ERET.
- fetch_exc  in  5  fetch-unit exception code for current PC (0 = none, 4 = AdEL).
- stall_pc  out  1  hold PC.
- if_jump  out  1  load next_pc.
- next_pc  out  32  branch target to load.
- if_handler  out  1  forced load of handler_pc; overrides stall_pc.
- handler_pc  out  32  forced target (HANDLER_PC or epc).
- flush_fd  out  1  kill the IF/ID register contents.
- fault_hold  out  1  high while in FAULT.

## Operation
- States: RUN, HOLD_BR, FAULT. Pending register pend_pc (32 b).
- Priority each cycle: Reset > exc_req > eret_req > branch (held or live) > stall > sequential.
- exc_req: if_handler=1, handler_pc=HANDLER_PC, flush_fd=1; pend_pc discarded; next state RUN, from any state.
- eret_req (no exc_req): if_handler=1, handler_pc=epc, flush_fd=1; pend_pc discarded; next state RUN.
- RUN, br_valid & !stall_req: if_jump=1, next_pc=br_target; stay RUN. No flush: the delay slot executes.
- RUN, br_valid & stall_req: stall_pc=1; pend_pc<=br_target; go HOLD_BR.
- HOLD_BR, stall_req: stall_pc=1, stay.
  - A new br_valid overwrites pend_pc (newest wins).
- HOLD_BR, !stall_req: if_jump=1, next_pc=pend_pc; go RUN.
- RUN, stall_req only: stall_pc=1.
- RUN, fetch_exc!=0, no stall and no redirect: go FAULT. Sequential fetch continues that cycle.
- FAULT: stall_pc=1 and fault_hold=1 every cycle; br_valid is ignored. Exit only via exc_req/eret_req.
- Idle outputs: if_jump=0, if_handler=0, flush_fd=0, stall_pc=0, next_pc=br_target, handler_pc=HANDLER_PC.

## Timing
- Redirect decision is combinational from inputs and state, consumed at the same rising edge by the fetch unit: zero-cycle redirect latency.
- State and pend_pc are registered and take effect the following cycle.
- A branch held across N stall cycles issues if_jump in the first cycle with stall_req=0. The PC lands on the target at that edge.
- Reset high: state<=RUN, pend_pc<=0. Outputs during Reset: stall_pc=0, if_jump=0, if_handler=0, flush_fd=1, fault_hold=0, next_pc=0, handler_pc=HANDLER_PC.
- Reset in HOLD_BR or FAULT aborts the held target or fault immediately.
- exc_req and eret_req together: exception wins and the ERET is dropped.
- exc_req together with br_valid: the branch is dropped, not buffered.

## Configuration
- FETCH_CTRL_STATS_EN defined: adds outputs redirect_cnt[31:0] and exc_cnt[31:0].
  - redirect_cnt increments on every cycle with if_jump|if_handler.
  - exc_cnt increments on every exc_req accepted.
  - Both counters clear on Reset and wrap at 2^32.
- Macro undefined: the ports and counters do not exist. Core behaviour is identical.

## Structure
- Shared package fetch_pkg: the state encoding (RUN=2'd0, HOLD_BR=2'd1, FAULT=2'd2), the exception codes NO_EXC=5'd0 and ADEL=5'd4, and the default IM_INIT, IM_END and HANDLER_PC values.
- One sub-module: fetch_ctrl_stats (the two counters), instantiated only under FETCH_CTRL_STATS_EN.

## Test plan
- Reset 2 cycles -> flush_fd=1, stall_pc=0, if_handler=0 during reset; fault_hold=0 after.
- br_valid=1, br_target=0x3040, stall_req=1 for 3 cycles, then stall low -> stall_pc=1 for 3 cycles, then if_jump=1 with next_pc=0x3040 for exactly one cycle.
- fetch_exc=4 at PC 0x5000 -> fault_hold=1 and stall_pc=1 from the next cycle. A br_valid in FAULT has no effect. exc_req -> if_handler=1, handler_pc=0x4180, flush_fd=1, then fault_hold=0.
- exc_req and eret_req with epc=0x3100 in the same cycle -> handler_pc=0x4180. eret_req alone next -> handler_pc=0x3100, flush_fd=1.
- HOLD_BR with pend_pc=0x3040, then exc_req -> handler redirect. The following stall-free cycle has if_jump=0, confirming the target was discarded.
- With FETCH_CTRL_STATS_EN: 2 branches plus 1 exception -> redirect_cnt=3, exc_cnt=1. Reset -> both 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencing controller: state encoding,
// fetch-unit exception codes and the default memory map / exception vector.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HOLD_BR = 2'd1,
      FAULT   = 2'd2
   } fetch_state_e;

   localparam logic [4:0]  NO_EXC          = 5'd0;
   localparam logic [4:0]  ADEL            = 5'd4;

   localparam logic [31:0] IM_INIT_DEF     = 32'h0000_3000;
   localparam logic [31:0] IM_END_DEF      = 32'h0000_4FFC;
   localparam logic [31:0] HANDLER_PC_DEF  = 32'h0000_4180;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl_stats.sv
// Redirect / exception event counters for the fetch controller.
// Only instantiated when FETCH_CTRL_STATS_EN is defined.
module fetch_ctrl_stats (
   input  logic        clk,
   input  logic        Reset,
   input  logic        redirect_i,
   input  logic        exc_i,
   output logic [31:0] redirect_cnt_o,
   output logic [31:0] exc_cnt_o
);

   logic [31:0] redirect_cnt_q;
   logic [31:0] redirect_cnt_d;
   logic [31:0] exc_cnt_q;
   logic [31:0] exc_cnt_d;

   // Next counter values; both wrap naturally at 2^32.
   always_comb begin
      redirect_cnt_d = redirect_cnt_q;
      exc_cnt_d      = exc_cnt_q;
      if (redirect_i) begin
         redirect_cnt_d = redirect_cnt_q + 32'd1;
      end else begin
         redirect_cnt_d = redirect_cnt_q;
      end
      if (exc_i) begin
         exc_cnt_d = exc_cnt_q + 32'd1;
      end else begin
         exc_cnt_d = exc_cnt_q;
      end
   end

   // Counter registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (Reset) begin
         redirect_cnt_q <= 32'd0;
         exc_cnt_q      <= 32'd0;
      end else begin
         redirect_cnt_q <= redirect_cnt_d;
         exc_cnt_q      <= exc_cnt_d;
      end
   end

   assign redirect_cnt_o = redirect_cnt_q;
   assign exc_cnt_o      = exc_cnt_q;

endmodule : fetch_ctrl_stats

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: arbitrates exception entry, ERET, branch
// resolution and hazard stalls in front of the instruction fetch unit.
// Redirect outputs are combinational (zero-cycle redirect); state and the
// pending branch target are registered.
// Optional feature: define FETCH_CTRL_STATS_EN to add redirect_cnt/exc_cnt.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
   parameter logic [31:0] IM_INIT    = IM_INIT_DEF,
   parameter logic [31:0] IM_END     = IM_END_DEF
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        stall_req,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   input  logic [4:0]  fetch_exc,
   output logic        stall_pc,
   output logic        if_jump,
   output logic [31:0] next_pc,
   output logic        if_handler,
   output logic [31:0] handler_pc,
   output logic        flush_fd,
`ifdef FETCH_CTRL_STATS_EN
   output logic [31:0] redirect_cnt,
   output logic [31:0] exc_cnt,
`endif
   output logic        fault_hold
);

   // The exception vector must lie inside the instruction memory window.
   if ((IM_INIT > IM_END) || (HANDLER_PC < IM_INIT) || (HANDLER_PC > IM_END)) begin : g_bad_cfg
      $error("fetch_ctrl: HANDLER_PC outside [IM_INIT, IM_END]");
   end

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  pend_pc_q;
   logic [31:0]  pend_pc_d;

   // State and pending-target registers.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= RUN;
         pend_pc_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Next-state selection; exception and ERET pull every state back to RUN
   // and throw away any buffered branch target.
   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      if (exc_req || eret_req) begin
         state_d   = RUN;
         pend_pc_d = 32'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (br_valid && stall_req) begin
                  state_d   = HOLD_BR;
                  pend_pc_d = br_target;
               end else if (br_valid || stall_req) begin
                  state_d = RUN;
               end else if (fetch_exc != NO_EXC) begin
                  state_d = FAULT;
               end else begin
                  state_d = RUN;
               end
            end
            HOLD_BR: begin
               if (stall_req) begin
                  state_d = HOLD_BR;
                  // Newest resolved branch replaces the buffered one.
                  if (br_valid) begin
                     pend_pc_d = br_target;
                  end else begin
                     pend_pc_d = pend_pc_q;
                  end
               end else begin
                  state_d = RUN;
               end
            end
            FAULT: begin
               state_d = FAULT;
            end
            default: begin
               state_d   = RUN;
               pend_pc_d = 32'd0;
            end
         endcase
      end
   end

   // Redirect outputs, decided in the same cycle as the requests.
   always_comb begin
      stall_pc   = 1'b0;
      if_jump    = 1'b0;
      next_pc    = br_target;
      if_handler = 1'b0;
      handler_pc = HANDLER_PC;
      flush_fd   = 1'b0;
      fault_hold = 1'b0;
      if (Reset) begin
         flush_fd = 1'b1;
         next_pc  = 32'd0;
      end else begin
         fault_hold = (state_q == FAULT);
         if (exc_req) begin
            if_handler = 1'b1;
            flush_fd   = 1'b1;
         end else if (eret_req) begin
            if_handler = 1'b1;
            handler_pc = epc;
            flush_fd   = 1'b1;
         end else begin
            case (state_q)
               RUN: begin
                  if (br_valid && !stall_req) begin
                     // Delay slot already in IF/ID executes, so no flush.
                     if_jump = 1'b1;
                  end else if (stall_req) begin
                     stall_pc = 1'b1;
                  end else begin
                     stall_pc = 1'b0;
                  end
               end
               HOLD_BR: begin
                  if (stall_req) begin
                     stall_pc = 1'b1;
                  end else begin
                     if_jump = 1'b1;
                     next_pc = pend_pc_q;
                  end
               end
               FAULT: begin
                  stall_pc = 1'b1;
               end
               default: begin
                  stall_pc = 1'b0;
               end
            endcase
         end
      end
   end

`ifdef FETCH_CTRL_STATS_EN
   fetch_ctrl_stats u_stats (
      .clk            (clk),
      .Reset          (Reset),
      .redirect_i     (if_jump | if_handler),
      .exc_i          (exc_req & ~Reset),
      .redirect_cnt_o (redirect_cnt),
      .exc_cnt_o      (exc_cnt)
   );
`endif

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. Expected outputs are pushed to a
// scoreboard queue as each cycle's stimulus is applied and popped when the
// DUT outputs are sampled on the falling edge.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam logic [31:0] HPC = 32'h0000_4180;

   typedef struct {
      logic        stall;
      logic        jump;
      logic [31:0] npc;
      logic        hnd;
      logic [31:0] hpc;
      logic        flush;
      logic        fhold;
   } exp_t;

   logic        clk = 1'b0;
   logic        Reset;
   logic        stall_req;
   logic        br_valid;
   logic [31:0] br_target;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [4:0]  fetch_exc;
   logic        stall_pc;
   logic        if_jump;
   logic [31:0] next_pc;
   logic        if_handler;
   logic [31:0] handler_pc;
   logic        flush_fd;
   logic        fault_hold;
`ifdef FETCH_CTRL_STATS_EN
   logic [31:0] redirect_cnt;
   logic [31:0] exc_cnt;
   logic [31:0] m_rc = 32'd0;
   logic [31:0] m_ec = 32'd0;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   int   m_state = 0;          // 0 RUN, 1 HOLD_BR, 2 FAULT
   logic [31:0] m_pend = 32'd0;

   fetch_ctrl dut (
      .clk        (clk),
      .Reset      (Reset),
      .stall_req  (stall_req),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .exc_req    (exc_req),
      .eret_req   (eret_req),
      .epc        (epc),
      .fetch_exc  (fetch_exc),
      .stall_pc   (stall_pc),
      .if_jump    (if_jump),
      .next_pc    (next_pc),
      .if_handler (if_handler),
      .handler_pc (handler_pc),
      .flush_fd   (flush_fd),
`ifdef FETCH_CTRL_STATS_EN
      .redirect_cnt (redirect_cnt),
      .exc_cnt      (exc_cnt),
`endif
      .fault_hold (fault_hold)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, predict, compare at negedge, advance model.
   task automatic step(input logic rst, input logic st, input logic bv, input logic [31:0] bt,
                       input logic ex, input logic er, input logic [31:0] ep, input logic [4:0] fe);
      exp_t e;
      exp_t got;
      Reset = rst; stall_req = st; br_valid = bv; br_target = bt;
      exc_req = ex; eret_req = er; epc = ep; fetch_exc = fe;
      e.stall = 1'b0; e.jump = 1'b0; e.npc = bt; e.hnd = 1'b0;
      e.hpc = HPC; e.flush = 1'b0; e.fhold = 1'b0;
      if (rst) begin
         e.flush = 1'b1; e.npc = 32'd0;
      end else begin
         e.fhold = (m_state == 2);
         if (ex) begin e.hnd = 1'b1; e.flush = 1'b1; end
         else if (er) begin e.hnd = 1'b1; e.flush = 1'b1; e.hpc = ep; end
         else if (m_state == 2) e.stall = 1'b1;
         else if (m_state == 1) begin
            if (st) e.stall = 1'b1;
            else begin e.jump = 1'b1; e.npc = m_pend; end
         end
         else if (bv && !st) e.jump = 1'b1;
         else if (st) e.stall = 1'b1;
      end
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      check_val("stall_pc",   {31'd0, stall_pc},   {31'd0, got.stall});
      check_val("if_jump",    {31'd0, if_jump},    {31'd0, got.jump});
      check_val("next_pc",    next_pc,             got.npc);
      check_val("if_handler", {31'd0, if_handler}, {31'd0, got.hnd});
      check_val("handler_pc", handler_pc,          got.hpc);
      check_val("flush_fd",   {31'd0, flush_fd},   {31'd0, got.flush});
      check_val("fault_hold", {31'd0, fault_hold}, {31'd0, got.fhold});
`ifdef FETCH_CTRL_STATS_EN
      check_val("redirect_cnt", redirect_cnt, m_rc);
      check_val("exc_cnt",      exc_cnt,      m_ec);
`endif
      @(posedge clk);
      #1;
`ifdef FETCH_CTRL_STATS_EN
      if (rst) begin m_rc = 32'd0; m_ec = 32'd0; end
      else begin
         if (got.jump || got.hnd) m_rc = m_rc + 32'd1;
         if (ex) m_ec = m_ec + 32'd1;
      end
`endif
      if (rst) begin m_state = 0; m_pend = 32'd0; end
      else if (ex || er) begin m_state = 0; m_pend = 32'd0; end
      else if (m_state == 0) begin
         if (bv && st) begin m_state = 1; m_pend = bt; end
         else if (!bv && !st && fe != NO_EXC) m_state = 2;
      end
      else if (m_state == 1) begin
         if (!st) m_state = 0;
         else if (bv) m_pend = bt;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0000_3004, 1'b0, 1'b0, 32'd0, NO_EXC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for two cycles.
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b1, 1'b1, 1'b1, 32'h3333, 1'b0, 1'b0, 32'h0, NO_EXC);
      idle(1);

      // Branch resolved under a 3-cycle stall, issued when the stall drops.
      step(1'b0, 1'b1, 1'b1, 32'h0000_3040, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b1, 1'b0, 32'h0000_3008, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b1, 1'b0, 32'h0000_3008, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b0, 1'b0, 32'h0000_3008, 1'b0, 1'b0, 32'h0, NO_EXC);
      idle(1);

      // Live branch with no stall.
      step(1'b0, 1'b0, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'h0, NO_EXC);

      // AdEL at 0x5000: FAULT, branch ignored, exception exits.
      step(1'b0, 1'b0, 1'b0, 32'h0000_5000, 1'b0, 1'b0, 32'h0, ADEL);
      step(1'b0, 1'b0, 1'b0, 32'h0000_5004, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b0, 1'b1, 32'h0000_3040, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b0, 1'b0, 32'h0000_5004, 1'b1, 1'b0, 32'h0, NO_EXC);
      idle(1);

      // Exception beats ERET; then ERET alone returns to epc.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3100, NO_EXC);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3100, NO_EXC);

      // Held target discarded by an exception.
      step(1'b0, 1'b1, 1'b1, 32'h0000_3040, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, NO_EXC);
      idle(1);

      // Newest branch wins while held.
      step(1'b0, 1'b1, 1'b1, 32'h0000_3040, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b1, 1'b1, 32'h0000_3080, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b0, 1'b0, 32'h0000_3000, 1'b0, 1'b0, 32'h0, NO_EXC);

      // Reset aborts a held branch; exception with a branch drops the branch.
      step(1'b0, 1'b1, 1'b1, 32'h0000_30C0, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NO_EXC);
      idle(1);
      step(1'b0, 1'b1, 1'b1, 32'h0000_3300, 1'b1, 1'b0, 32'h0, NO_EXC);
      idle(1);

`ifdef FETCH_CTRL_STATS_EN
      // Two branches plus one exception after reset.
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b0, 1'b1, 32'h0000_3010, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b0, 1'b1, 32'h0000_3020, 1'b0, 1'b0, 32'h0, NO_EXC);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, NO_EXC);
      #1;
      check_val("redirect_cnt_3", redirect_cnt, 32'd3);
      check_val("exc_cnt_1",      exc_cnt,      32'd1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NO_EXC);
      #1;
      check_val("redirect_cnt_clr", redirect_cnt, 32'd0);
      check_val("exc_cnt_clr",      exc_cnt,      32'd0);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 60) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              32'h0000_3000 + {$urandom_range(0, 1023), 2'b00},
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0),
              32'h0000_3000 + {$urandom_range(0, 1023), 2'b00},
              ($urandom_range(0, 7) == 0) ? ADEL : NO_EXC);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_ctrl
